// File: rtl/dircc_types_pkg.sv
// Shared types and header-field constants for the DIRCC packet router.
package dircc_types_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FWD_LOCAL = 2'd1,
      FWD_NET   = 2'd2,
      DROP      = 2'd3
   } router_state_e;

   localparam int          HDR_HWADDR_MSB   = 31;
   localparam int          HDR_HWADDR_LSB   = 16;
   localparam logic [15:0] BROADCAST_HWADDR = 16'hFFFF;

   // Broadcast never loops back locally, even if our own address is all-ones.
   function automatic logic is_local_hdr(input logic [15:0] hw_addr, input logic [15:0] own_addr);
      return (hw_addr == own_addr) && (hw_addr != BROADCAST_HWADDR);
   endfunction

endpackage

// File: rtl/dircc_st_output_reg.sv
// Single-entry Avalon-ST output register: one beat of storage, loaded when the
// router writes it, drained by the downstream ready.
module dircc_st_output_reg #(
   parameter int DATA_WIDTH  = 32,
   parameter int EMPTY_WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   load_i,
   input  logic [DATA_WIDTH-1:0]  data_i,
   input  logic [EMPTY_WIDTH-1:0] empty_i,
   input  logic                   sop_i,
   input  logic                   eop_i,
   output logic [DATA_WIDTH-1:0]  data_o,
   output logic [EMPTY_WIDTH-1:0] empty_o,
   output logic                   sop_o,
   output logic                   eop_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic                   free_o
);

   logic                   valid_q, valid_d;
   logic [DATA_WIDTH-1:0]  data_q;
   logic [EMPTY_WIDTH-1:0] empty_q;
   logic                   sop_q, eop_q;

   always_comb begin
      valid_d = valid_q;
      if (load_i) begin
         valid_d = 1'b1;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Payload needs no reset; it is only observed while valid is high.
   always_ff @(posedge clk) begin
      if (load_i) begin
         data_q  <= data_i;
         empty_q <= empty_i;
         sop_q   <= sop_i;
         eop_q   <= eop_i;
      end
   end

   assign data_o  = data_q;
   assign empty_o = empty_q;
   assign sop_o   = sop_q;
   assign eop_o   = eop_q;
   assign valid_o = valid_q;
   assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/dircc_packet_router.sv
// Routes Avalon-ST packets from the processing element to the local loopback or
// the network by header hw_addr; headerless packets are dropped. Latency 1 beat.
module dircc_packet_router
   import dircc_types_pkg::*;
#(
   parameter int  BITS_PER_SYMBOL   = 8,
   parameter int  SYMBOLS_PER_BEAT  = 4,
   parameter int  MEM_ADDRESS_WIDTH = 32,
   localparam int DATA_WIDTH        = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
   localparam int EMPTY_WIDTH       = $clog2(SYMBOLS_PER_BEAT)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [MEM_ADDRESS_WIDTH-1:0] address,

   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic [EMPTY_WIDTH-1:0]       in_empty,
   input  logic                         in_startofpacket,
   input  logic                         in_endofpacket,
   input  logic                         in_valid,
   output logic                         in_ready,

   output logic [DATA_WIDTH-1:0]        local_data,
   output logic [EMPTY_WIDTH-1:0]       local_empty,
   output logic                         local_startofpacket,
   output logic                         local_endofpacket,
   output logic                         local_valid,
   input  logic                         local_ready,

   output logic [DATA_WIDTH-1:0]        net_data,
   output logic [EMPTY_WIDTH-1:0]       net_empty,
   output logic                         net_startofpacket,
   output logic                         net_endofpacket,
   output logic                         net_valid,
   input  logic                         net_ready,

   output logic [15:0]                  local_count,
   output logic [15:0]                  net_count,
   output logic [15:0]                  drop_count
);

   router_state_e state_q, state_d;
   logic [15:0]   local_cnt_q, local_cnt_d;
   logic [15:0]   net_cnt_q, net_cnt_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;
   logic          rdy;
   logic          load_local, load_net;
   logic          local_free, net_free;
   logic          hdr_local;
   logic          addr_unused;

   // Only the low 16 address bits take part in routing.
   assign addr_unused = ^address;
   assign hdr_local   = is_local_hdr(in_data[HDR_HWADDR_MSB:HDR_HWADDR_LSB], address[15:0]);

   always_comb begin
      state_d     = state_q;
      rdy         = 1'b0;
      load_local  = 1'b0;
      load_net    = 1'b0;
      local_cnt_d = local_cnt_q;
      net_cnt_d   = net_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (!in_startofpacket) begin
                  rdy        = 1'b1;
                  drop_cnt_d = drop_cnt_q + 16'd1;
                  if (!in_endofpacket) state_d = DROP;
               end else if (hdr_local) begin
                  rdy = local_free;
                  if (local_free) begin
                     load_local  = 1'b1;
                     local_cnt_d = local_cnt_q + 16'd1;
                     if (!in_endofpacket) state_d = FWD_LOCAL;
                  end
               end else begin
                  rdy = net_free;
                  if (net_free) begin
                     load_net  = 1'b1;
                     net_cnt_d = net_cnt_q + 16'd1;
                     if (!in_endofpacket) state_d = FWD_NET;
                  end
               end
            end
         end
         FWD_LOCAL: begin
            rdy = local_free;
            if (in_valid && local_free) begin
               load_local = 1'b1;
               if (in_endofpacket) state_d = IDLE;
            end
         end
         FWD_NET: begin
            rdy = net_free;
            if (in_valid && net_free) begin
               load_net = 1'b1;
               if (in_endofpacket) state_d = IDLE;
            end
         end
         DROP: begin
            rdy = 1'b1;
            if (in_valid && in_endofpacket) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         local_cnt_q <= 16'd0;
         net_cnt_q   <= 16'd0;
         drop_cnt_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         local_cnt_q <= local_cnt_d;
         net_cnt_q   <= net_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign in_ready    = reset_n && rdy;
   assign local_count = local_cnt_q;
   assign net_count   = net_cnt_q;
   assign drop_count  = drop_cnt_q;

   dircc_st_output_reg #(.DATA_WIDTH(DATA_WIDTH), .EMPTY_WIDTH(EMPTY_WIDTH)) u_local_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (load_local),
      .data_i  (in_data),
      .empty_i (in_empty),
      .sop_i   (in_startofpacket),
      .eop_i   (in_endofpacket),
      .data_o  (local_data),
      .empty_o (local_empty),
      .sop_o   (local_startofpacket),
      .eop_o   (local_endofpacket),
      .valid_o (local_valid),
      .ready_i (local_ready),
      .free_o  (local_free)
   );

   dircc_st_output_reg #(.DATA_WIDTH(DATA_WIDTH), .EMPTY_WIDTH(EMPTY_WIDTH)) u_net_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (load_net),
      .data_i  (in_data),
      .empty_i (in_empty),
      .sop_i   (in_startofpacket),
      .eop_i   (in_endofpacket),
      .data_o  (net_data),
      .empty_o (net_empty),
      .sop_o   (net_startofpacket),
      .eop_o   (net_endofpacket),
      .valid_o (net_valid),
      .ready_i (net_ready),
      .free_o  (net_free)
   );

endmodule

// File: tb/tb_dircc_packet_router.sv
// Scoreboard bench for dircc_packet_router: table of packets plus stall and reset sequences.
module tb_dircc_packet_router;
   import dircc_types_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] address;
   logic [31:0] in_data;
   logic [1:0]  in_empty;
   logic        in_startofpacket, in_endofpacket, in_valid, in_ready;
   logic [31:0] local_data, net_data;
   logic [1:0]  local_empty, net_empty;
   logic        local_startofpacket, local_endofpacket, local_valid, local_ready;
   logic        net_startofpacket, net_endofpacket, net_valid, net_ready;
   logic [15:0] local_count, net_count, drop_count;

   dircc_packet_router dut (
      .clk(clk), .reset_n(reset_n), .address(address),
      .in_data(in_data), .in_empty(in_empty), .in_startofpacket(in_startofpacket),
      .in_endofpacket(in_endofpacket), .in_valid(in_valid), .in_ready(in_ready),
      .local_data(local_data), .local_empty(local_empty),
      .local_startofpacket(local_startofpacket), .local_endofpacket(local_endofpacket),
      .local_valid(local_valid), .local_ready(local_ready),
      .net_data(net_data), .net_empty(net_empty), .net_startofpacket(net_startofpacket),
      .net_endofpacket(net_endofpacket), .net_valid(net_valid), .net_ready(net_ready),
      .local_count(local_count), .net_count(net_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  empty;
      logic        sop;
      logic        eop;
      int          acc;
   } beat_t;

   typedef struct {
      logic [15:0] hw;
      int          nbeats;
      bit          with_sop;
      logic [1:0]  last_empty;
      int          port;       // 0 local, 1 net, 2 drop
   } vec_t;

   beat_t       exp_local[$];
   beat_t       exp_net[$];
   int          checks = 0;
   int          errors = 0;
   bit          lat_chk = 1'b0;
   int          exp_lc = 0, exp_nc = 0, exp_dc = 0;
   int          first_acc, last_acc;
   logic [31:0] pkt_dat[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic cmp_beat(input string port, input beat_t e, input logic [31:0] d,
                           input logic [1:0] emp, input logic sop, input logic eop);
      chk({port, "_beat"}, {d, emp, sop, eop}, {e.data, e.empty, e.sop, e.eop});
      if (lat_chk) chk({port, "_latency"}, 64'(cyc), 64'(e.acc));
   endtask

   // Handshake seen at the negedge completes on the following posedge.
   always @(negedge clk) begin
      beat_t e;
      if (local_valid === 1'b1 && local_ready) begin
         if (exp_local.size() == 0) begin
            checks++; errors++;
            $display("FAIL local_unexpected actual=%h required=no_beat", local_data);
         end else begin
            e = exp_local.pop_front();
            cmp_beat("local", e, local_data, local_empty, local_startofpacket, local_endofpacket);
         end
      end
      if (net_valid === 1'b1 && net_ready) begin
         if (exp_net.size() == 0) begin
            checks++; errors++;
            $display("FAIL net_unexpected actual=%h required=no_beat", net_data);
         end else begin
            e = exp_net.pop_front();
            cmp_beat("net", e, net_data, net_empty, net_startofpacket, net_endofpacket);
         end
      end
   end

   task automatic drive_beat(input logic [31:0] d, input logic sop, input logic eop,
                             input logic [1:0] emp, input int port, output bit ok);
      beat_t b;
      in_data = d; in_startofpacket = sop; in_endofpacket = eop; in_empty = emp;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = (in_ready === 1'b1);
         @(posedge clk); #1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL accept_timeout actual=not_accepted required=accepted data=%h", d);
      end else begin
         last_acc = cyc;
         b.data = d; b.empty = emp; b.sop = sop; b.eop = eop; b.acc = cyc;
         if (port == 0) exp_local.push_back(b);
         else if (port == 1) exp_net.push_back(b);
      end
   endtask

   task automatic send_pkt(input logic [15:0] hw, input int nb, input bit with_sop,
                           input logic [1:0] last_empty, input int port);
      bit          ok;
      logic [31:0] d;
      logic [15:0] lo;
      for (int b = 0; b < nb; b++) begin
         lo = 16'($urandom);
         d  = (b == 0) ? {hw, lo} : $urandom;
         pkt_dat[b] = d;
         drive_beat(d, with_sop && (b == 0), b == nb - 1, (b == nb - 1) ? last_empty : 2'd0, port, ok);
         if (b == 0) begin
            first_acc = last_acc;
            if (ok) begin
               if (port == 0) exp_lc++;
               else if (port == 1) exp_nc++;
               else exp_dc++;
            end
         end
      end
      in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      exp_local.delete(); exp_net.delete();
      exp_lc = 0; exp_nc = 0; exp_dc = 0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic drain(input string tag);
      for (int n = 0; n < 100 && (exp_local.size() != 0 || exp_net.size() != 0); n++) begin
         @(posedge clk); #1;
      end
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_local_left"}, 64'(exp_local.size()), 64'd0);
      chk({tag, "_net_left"}, 64'(exp_net.size()), 64'd0);
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_local_count"}, 64'(local_count), 64'(exp_lc));
      chk({tag, "_net_count"}, 64'(net_count), 64'(exp_nc));
      chk({tag, "_drop_count"}, 64'(drop_count), 64'(exp_dc));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

   initial begin
      vec_t vecs[7];
      bit   ok;
      int   l_last;

      vecs[0] = '{16'h0005, 3, 1'b1, 2'd0, 0};
      vecs[1] = '{16'h0007, 1, 1'b1, 2'd2, 1};
      vecs[2] = '{16'h0005, 2, 1'b0, 2'd0, 2};
      vecs[3] = '{16'h0005, 2, 1'b1, 2'd1, 0};
      vecs[4] = '{16'hFFFF, 2, 1'b1, 2'd3, 1};
      vecs[5] = '{16'h0005, 1, 1'b1, 2'd3, 0};
      vecs[6] = '{16'h1234, 4, 1'b1, 2'd1, 1};

      address = 32'h0000_0005;
      in_data = 32'h0005_0000; in_empty = 2'd0;
      in_startofpacket = 1'b1; in_endofpacket = 1'b0; in_valid = 1'b1;
      local_ready = 1'b1; net_ready = 1'b1;
      reset_n = 1'b0;

      // Reset state, with a valid header already presented.
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_local_valid", 64'(local_valid), 64'd0);
      chk("rst_net_valid", 64'(net_valid), 64'd0);
      chk("rst_counts", {16'd0, local_count, net_count, drop_count}, 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0; in_startofpacket = 1'b0;
      reset_n = 1'b1;

      lat_chk = 1'b1;
      foreach (vecs[i]) begin
         send_pkt(vecs[i].hw, vecs[i].nbeats, vecs[i].with_sop, vecs[i].last_empty, vecs[i].port);
      end
      drain("table");
      chk_counts("table");
      chk("table_state_idle", 64'(dut.state_q), 64'(IDLE));

      // Back-to-back local then net, no idle cycle between packets.
      do_reset();
      send_pkt(16'h0005, 3, 1'b1, 2'd0, 0);
      l_last = last_acc;
      send_pkt(16'h0007, 2, 1'b1, 2'd0, 1);
      chk("b2b_no_gap", 64'(first_acc), 64'(l_last + 1));
      drain("b2b");
      chk_counts("b2b");

      // Network stall mid-packet.
      do_reset();
      lat_chk = 1'b0;
      fork
         send_pkt(16'h0009, 4, 1'b1, 2'd0, 1);
         begin
            repeat (2) @(posedge clk);
            #1;
            net_ready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               chk("stall_net_data", 64'(net_data), 64'(pkt_dat[1]));
               chk("stall_net_valid", 64'(net_valid), 64'd1);
               chk("stall_in_ready", 64'(in_ready), 64'd0);
            end
            @(posedge clk); #1;
            net_ready = 1'b1;
         end
      join
      drain("stall");
      chk_counts("stall");

      // Reset during beat 2 of a 4-beat packet; only the new packet may appear.
      do_reset();
      lat_chk = 1'b1;
      drive_beat(32'h000A_1111, 1'b1, 1'b0, 2'd0, 1, ok);
      drive_beat(32'h2222_2222, 1'b0, 1'b0, 2'd0, 1, ok);
      in_data = 32'h3333_3333; in_startofpacket = 1'b0; in_endofpacket = 1'b0; in_valid = 1'b1;
      reset_n = 1'b0;
      exp_local.delete(); exp_net.delete();
      exp_lc = 0; exp_nc = 0; exp_dc = 0;
      @(negedge clk);
      chk("midrst_in_ready", 64'(in_ready), 64'd0);
      chk("midrst_net_valid", 64'(net_valid), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      reset_n = 1'b1;
      send_pkt(16'h000B, 2, 1'b1, 2'd1, 1);
      drain("midrst");
      chk_counts("midrst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dircc_packet_router.md
DIRCC_PACKET_ROUTER -- requirements
Module: dircc_packet_router

Interface
REQ-001 SHALL have parameter BITS_PER_SYMBOL, default 8, bits per Avalon-ST symbol.
REQ-002 SHALL have parameter SYMBOLS_PER_BEAT, default 4, symbols per beat; DATA_WIDTH = product (32), EMPTY_WIDTH = clog2(SYMBOLS_PER_BEAT).
REQ-003 SHALL have parameter MEM_ADDRESS_WIDTH, default 32, width of own node address.
REQ-004 clk  input  1  clock, rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 address  input  MEM_ADDRESS_WIDTH  own hardware address; only bits [15:0] are compared.
REQ-007 in_data/in_empty/in_startofpacket/in_endofpacket/in_valid  input  DATA_WIDTH/EMPTY_WIDTH/1/1/1  Avalon-ST sink fed by the processing element output.
REQ-008 in_ready  output  1  sink backpressure.
REQ-009 local_data/local_empty/local_startofpacket/local_endofpacket/local_valid  output  as sink  Avalon-ST source looped back to the local processing element input.
REQ-010 local_ready  input  1  local backpressure.
REQ-011 net_data/net_empty/net_startofpacket/net_endofpacket/net_valid  output  as sink  Avalon-ST source to the network.
REQ-012 net_ready  input  1  network backpressure.
REQ-013 local_count, net_count, drop_count  output  16 each  packet counters.

Function
REQ-014 Header beat (sop) bits [31:16] SHALL carry the destination hw_addr.
REQ-015 FSM states SHALL be IDLE, FWD_LOCAL, FWD_NET, DROP.
REQ-016 IDLE, valid sop beat: hw_addr == address[15:0] -> local, else (including 16'hFFFF) -> net.
REQ-017 IDLE, valid beat without sop -> drop: beat consumed (in_ready=1), drop_count +1; eop -> stay IDLE, else -> DROP.
REQ-018 DROP: in_ready=1, discard beats, return to IDLE on accepted eop beat.
REQ-019 Each source SHALL have one output register; a beat is accepted when in_valid && in_ready and appears on the selected source the next cycle (latency 1).
REQ-020 Forwarding in_ready = !sel_valid || sel_ready (sel = port chosen by header or current state); unselected source is never written.
REQ-021 Output register holds data stable while valid && !ready; valid clears on ready when no new beat accepted.
REQ-022 Accepted sop beat SHALL enter FWD_LOCAL/FWD_NET unless it also has eop (single-beat packet -> stay IDLE).
REQ-023 Forward state returns to IDLE on accepted eop beat; next-cycle sop beat may be routed to the other port without a gap if that port's register is free.
REQ-024 sop inside a forward state SHALL be forwarded unchanged; no re-route.
REQ-025 local_count/net_count +1 when the sop beat of a packet is accepted into that port; all counters wrap at 16 bits.
REQ-026 empty, sop, eop, data SHALL pass through bit-exact.

Reset
REQ-027 reset_n low SHALL force state IDLE, all *_valid 0, counters 0, in_ready 0 while asserted; data/empty registers undefined.
REQ-028 Reset mid-packet SHALL abandon the packet; no partial eop is generated afterwards.

Structure
REQ-029 Router state enum and HDR_HWADDR_MSB/LSB (31/16) and BROADCAST_HWADDR (16'hFFFF) constants SHALL live in dircc_types_pkg.
REQ-030 One sub-module dircc_st_output_reg (single-entry Avalon-ST register) SHALL be instantiated twice.

Verification
REQ-031 address=0x5; 3-beat packet hdr 0x0005_0000, ready=1 -> 3 beats on local, 1 cycle latency, local_count=1, net silent.
REQ-032 hdr 0x0007_0001 single beat sop+eop, empty=2 -> 1 net beat, empty=2, net_count=1, state IDLE.
REQ-033 net_ready=0 for 4 cycles mid 4-beat packet -> net_data held stable, in_ready=0, no beat lost or duplicated.
REQ-034 2-beat packet without sop -> both consumed, no output, drop_count=1; following local sop packet routes correctly.
REQ-035 back-to-back local then net packets, both readies high -> no idle cycle between packets, counters 1/1.
REQ-036 reset_n low during beat 2 of 4 then release, new net packet -> only new packet appears, net_count=1.
